// File: rtl/br_status_pkg.sv
// Shared branch status buffer definitions: entry layout, word address width
// and the resolve FSM state encoding.
`ifndef PredMaxDepth
`define PredMaxDepth 16
`endif

package br_status_pkg;

    localparam int WORD_AW = 30;

    typedef struct packed {
        logic [WORD_AW-1:0] pc;
        logic [WORD_AW-1:0] pred_target;
        logic               pred_taken;
        logic [2:0]         rsv;
    } br_status_t;

    typedef enum logic [0:0] {
        RS_IDLE    = 1'b0,
        RS_RECOVER = 1'b1
    } rs_state_e;

endpackage

// File: rtl/br_resolve_unit_if.sv
// Resolve-unit bus: execute-side branch input, status buffer read/writeback,
// front-end redirect, predictor update and recovery stall.
interface br_resolve_unit_if
    import br_status_pkg::*;
#(
    parameter int DATA = 64,
    parameter int ADDR = 4
);
    logic               exe_br_valid_;
    logic [ADDR-1:0]    exe_br_tag;
    logic               exe_taken;
    logic [WORD_AW-1:0] exe_target;
    logic [ADDR-1:0]    exe_st_idx;
    logic [DATA-1:0]    exe_status;
    logic [ADDR-1:0]    wb_st_idx;
    logic               wb_flush_;
    logic               redirect_;
    logic [31:0]        redirect_pc;
    logic               upd_valid_;
    logic [31:0]        upd_pc;
    logic               upd_taken;
    logic               recover_busy;

    modport master (
        output exe_br_valid_, exe_br_tag, exe_taken, exe_target, exe_status,
        input  exe_st_idx, wb_st_idx, wb_flush_, redirect_, redirect_pc,
               upd_valid_, upd_pc, upd_taken, recover_busy
    );

    modport slave (
        input  exe_br_valid_, exe_br_tag, exe_taken, exe_target, exe_status,
        output exe_st_idx, wb_st_idx, wb_flush_, redirect_, redirect_pc,
               upd_valid_, upd_pc, upd_taken, recover_busy
    );
endinterface

// File: rtl/br_miss_detect.sv
// Combinational mispredict compare and corrected fetch PC for one resolved
// branch against its recorded prediction.
module br_miss_detect
    import br_status_pkg::*;
(
    input  br_status_t         status_i,
    input  logic               exe_taken_i,
    input  logic [WORD_AW-1:0] exe_target_i,
    output logic               miss_o,
    output logic [31:0]        correct_pc_o
);
    logic [WORD_AW-1:0] fall_thru;
    logic               unused_rsv;

    // Word-address increment wraps naturally at the top of the 2^30 space.
    assign fall_thru = status_i.pc + WORD_AW'(1);

    assign miss_o = (exe_taken_i != status_i.pred_taken) ||
                    (exe_taken_i && (exe_target_i != status_i.pred_target));

    assign correct_pc_o = {(exe_taken_i ? exe_target_i : fall_thru), 2'b00};

    assign unused_rsv = ^status_i.rsv;

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: consumes resolved branches, flags mispredicts and
// sequences recovery. Optional statistics counters under BR_RESOLVE_STAT_EN.
module br_resolve_unit
    import br_status_pkg::*;
#(
    parameter int DATA        = 64,
    parameter int DEPTH       = `PredMaxDepth,
    parameter int ADDR        = $clog2(DEPTH),
    parameter int RECOVER_CYC = 2
) (
    input  logic               clk,
    input  logic               reset_,
`ifdef BR_RESOLVE_STAT_EN
    output logic [31:0]        stat_br_cnt,
    output logic [31:0]        stat_miss_cnt,
`endif
    br_resolve_unit_if.slave   bus
);
    br_status_t      status;
    logic            miss;
    logic [31:0]     correct_pc;
    logic            accept;

    rs_state_e       state_q;
    logic [3:0]      cnt_q;
    logic            busy_q;
    logic            flush_q;
    logic            redir_q;
    logic            upd_v_q;
    logic [ADDR-1:0] wb_idx_q;
    logic [31:0]     redir_pc_q;
    logic [31:0]     upd_pc_q;
    logic            upd_taken_q;

    assign bus.exe_st_idx = bus.exe_br_tag;
    assign status         = bus.exe_status;

    // Anything arriving while recovering is younger than the flushed branch.
    assign accept = (state_q == RS_IDLE) && !bus.exe_br_valid_;

    br_miss_detect u_miss_detect (
        .status_i     (status),
        .exe_taken_i  (bus.exe_taken),
        .exe_target_i (bus.exe_target),
        .miss_o       (miss),
        .correct_pc_o (correct_pc)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= RS_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            flush_q     <= 1'b1;
            redir_q     <= 1'b1;
            upd_v_q     <= 1'b1;
            wb_idx_q    <= '0;
            redir_pc_q  <= '0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            flush_q <= 1'b1;
            redir_q <= 1'b1;
            upd_v_q <= 1'b1;
            case (state_q)
                RS_IDLE: begin
                    if (accept) begin
                        upd_v_q     <= 1'b0;
                        upd_pc_q    <= {status.pc, 2'b00};
                        upd_taken_q <= bus.exe_taken;
                        wb_idx_q    <= bus.exe_br_tag;
                        if (miss) begin
                            flush_q    <= 1'b0;
                            redir_q    <= 1'b0;
                            redir_pc_q <= correct_pc;
                            state_q    <= RS_RECOVER;
                            cnt_q      <= 4'(RECOVER_CYC - 1);
                            busy_q     <= 1'b1;
                        end
                    end
                end
                RS_RECOVER: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RS_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= RS_IDLE;
            endcase
        end
    end

    assign bus.wb_st_idx    = wb_idx_q;
    assign bus.wb_flush_    = flush_q;
    assign bus.redirect_    = redir_q;
    assign bus.redirect_pc  = redir_pc_q;
    assign bus.upd_valid_   = upd_v_q;
    assign bus.upd_pc       = upd_pc_q;
    assign bus.upd_taken    = upd_taken_q;
    assign bus.recover_busy = busy_q;

`ifdef BR_RESOLVE_STAT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept && (br_cnt_q != '1))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (accept && miss && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign stat_br_cnt   = br_cnt_q;
    assign stat_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/br_resolve_unit.md
# br_resolve_unit

Consumer side of the branch status buffer. Takes resolved branches from the branch execution unit, reads each branch's prediction record through the buffer's execute port, and detects mispredictions. It then drives the buffer's writeback index/flush pair, the front-end redirect and the predictor update one cycle later. It also sequences a fixed-length recovery window after every flush.

## Interface
- DATA, 64: status entry width; must equal $bits(br_status_t)
- DEPTH, `PredMaxDepth: status buffer depth
- ADDR, $clog2(DEPTH): tag width
- RECOVER_CYC, 2: recovery cycles after a flush (1..15)

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- exe_br_valid_  in  1  resolved branch present (active low)
- exe_br_tag  in  ADDR  status buffer index of the branch
- exe_taken  in  1  actual direction
- exe_target  in  30  actual target, word address
- exe_st_idx  out  ADDR  status buffer read index (= exe_br_tag, combinational)
- exe_status  in  DATA  status entry read at exe_st_idx
- wb_st_idx  out  ADDR  writeback index to the status buffer
- wb_flush_  out  1  flush younger entries (active low, one-cycle pulse)
- redirect_  out  1  front-end redirect strobe (active low)
- redirect_pc  out  32  corrected fetch PC, byte address
- upd_valid_  out  1  predictor update strobe (active low)
- upd_pc  out  32  branch PC, byte address
- upd_taken  out  1  actual direction
- recover_busy  out  1  front end must stall

## Operation
- Branches reach this block in program order; at most one per cycle.
- Status decode: pc = exe_status[63:34], pred_target = [33:4], pred_taken = [3]; [2:0] reserved and ignored.
- Mispredict = (exe_taken != pred_taken) || (exe_taken && exe_target != pred_target).
- Correct PC: exe_taken ? exe_target : pc+1. The word add wraps mod 2^30. Output is {pc30, 2'b00}.
- FSM states:
  - IDLE: accepts valid exe input; mispredict -> RECOVER.
  - RECOVER: counter loads RECOVER_CYC-1 and decrements; -> IDLE when it reaches 0 and decrements.
  - In RECOVER, exe inputs are dropped. They are younger than the flushed branch.
- Every accepted branch produces upd_valid_ in the next cycle.
- A mispredicted branch also produces wb_flush_ = 0 and redirect_ = 0 in that same next cycle.
- wb_st_idx holds the tag of the last accepted branch; it is not meaningful to the buffer unless wb_flush_ is low.

## Timing
- Cycle N: exe input valid; exe_st_idx = exe_br_tag and exe_status is used combinationally.
- Cycle N+1: all wb/redirect/upd outputs are registered and valid for exactly one cycle.
- recover_busy is high from N+1 through N+RECOVER_CYC inclusive.
- Back-to-back correct branches: one result per cycle, no bubbles.
- An exe input arriving in cycle N+1 of a flush (same cycle as wb_flush_) is dropped.
- Reset values:
  - wb_flush_, redirect_, upd_valid_ = 1
  - wb_st_idx, redirect_pc, upd_pc, upd_taken = 0
  - recover_busy = 0
  - FSM = IDLE, counter = 0
- Reset mid-RECOVER returns to IDLE immediately.

## Configuration
- BR_RESOLVE_STAT_EN defined: adds two 32-bit saturating counters, stat_br_cnt (accepted branches) and stat_miss_cnt (mispredicts), on output ports of the same names. Both reset to 0 and increment in cycle N+1.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package br_status_pkg: br_status_t packed struct (pc, pred_target, pred_taken, rsv), WORD_AW = 30, the resolve FSM state enum.
- br_status_buf is updated to size DATA from br_status_pkg.
- One sub-module, br_miss_detect: combinational mispredict compare and correct-PC generation.
- FSM, counter and output registers stay in br_resolve_unit.

## Test plan
- Correct not-taken: tag 3, pc 0x100, pred_taken 0, exe_taken 0 -> N+1: upd_valid_=0, upd_pc=0x400, wb_flush_=1, redirect_=1.
- Direction miss: tag 5, pc 0x200, pred_taken 0, exe_taken 1, target 0x300 -> N+1: wb_flush_=0, wb_st_idx=5, redirect_pc=0xC00; recover_busy high 2 cycles.
- Target miss: pred_taken 1, pred_target 0x40, exe_target 0x44 -> flush, redirect_pc=0x110. Same target -> no flush.
- Fall-through wrap: pc 0x3FFFFFFF, mispredicted taken, actual not taken -> redirect_pc=0x0.
- Drop during recovery: valid branch in cycles N+1 and N+2 after a flush -> no upd_valid_ for them. Branch at N+3 is accepted.
- Reset asserted during RECOVER -> recover_busy=0 and all strobes high immediately. With BR_RESOLVE_STAT_EN, counters read 0 after reset.
